conv_seq_ctrl: RTL and testbench

//  Top-level sequencer for one convolution pass: im2col expansion, then GEMM on the expanded matrix.

---
 rtl/conv_ctrl_pkg.sv | 38 +++
 rtl/conv_mem_mux.sv | 47 ++++
 rtl/conv_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: sequencer state and RAM-owner encodings shared by the
// convolution-pass controller and its RAM port mux.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IM2COL  = 3'd1,
        ST_GEMM_GO = 3'd2,
        ST_GEMM    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I2C  = 2'd1,
        OWN_GEMM = 2'd2
    } owner_t;

    localparam int STATE_W = 3;

    // The shared RAM belongs to whichever engine the given state is running.
    function automatic owner_t owner_of(input state_t s);
        owner_t o;
        o = OWN_NONE;
        case (s)
            ST_IM2COL:           o = OWN_I2C;
            ST_GEMM_GO, ST_GEMM: o = OWN_GEMM;
            default:             o = OWN_NONE;
        endcase
        return o;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == ST_IM2COL) || (s == ST_GEMM_GO) || (s == ST_GEMM);
    endfunction

endpackage

// File: rtl/conv_mem_mux.sv
// conv_mem_mux: grants the single shared RAM port to the engine named by the
// registered owner code; with no owner every field, including wr_en, is zero.
module conv_mem_mux
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  owner_t                owner,
    input  logic [ADDR_WIDTH-1:0] i2c_addr_rd,
    input  logic [ADDR_WIDTH-1:0] i2c_addr_wr,
    input  logic [DATA_WIDTH-1:0] i2c_data_wr,
    input  logic                  i2c_wr_en,
    input  logic [ADDR_WIDTH-1:0] gm_addr_rd,
    input  logic [ADDR_WIDTH-1:0] gm_addr_wr,
    input  logic [DATA_WIDTH-1:0] gm_data_wr,
    input  logic                  gm_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic                  mem_wr_en
);

    always_comb begin
        mem_addr_rd = '0;
        mem_addr_wr = '0;
        mem_data_wr = '0;
        mem_wr_en   = 1'b0;
        case (owner)
            OWN_I2C: begin
                mem_addr_rd = i2c_addr_rd;
                mem_addr_wr = i2c_addr_wr;
                mem_data_wr = i2c_data_wr;
                mem_wr_en   = i2c_wr_en;
            end
            OWN_GEMM: begin
                mem_addr_rd = gm_addr_rd;
                mem_addr_wr = gm_addr_wr;
                mem_data_wr = gm_data_wr;
                mem_wr_en   = gm_wr_en;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences one convolution pass (im2col, then GEMM), runs a
// per-phase watchdog, counts busy cycles and owns the shared RAM port.
module conv_seq_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PERF_WIDTH-1:0] perf_cycles,
    output logic                  rst_im2col,
    input  logic                  im2col_done,
    input  logic [ADDR_WIDTH-1:0] i2c_addr_rd,
    input  logic [ADDR_WIDTH-1:0] i2c_addr_wr,
    input  logic [DATA_WIDTH-1:0] i2c_data_wr,
    input  logic                  i2c_wr_en,
    output logic                  gemm_start,
    input  logic                  gemm_done,
    input  logic [ADDR_WIDTH-1:0] gm_addr_rd,
    input  logic [ADDR_WIDTH-1:0] gm_addr_wr,
    input  logic [DATA_WIDTH-1:0] gm_data_wr,
    input  logic                  gm_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic                  mem_wr_en,
    output logic [STATE_W-1:0]    state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    owner_t          owner;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_hit;
    logic            run_accept;

    // Handshake: start is a request level sampled only in IDLE/ERR (abort has
    // priority); done and gemm_start are single-cycle pulses; im2col_done and
    // gemm_done are completion levels honoured only in their own phase.
    assign wd_hit    = (wd_cnt == WD_LAST);
    assign busy      = is_busy(state);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        run_accept = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt  = ST_IM2COL;
                    run_accept = 1'b1;
                end
            end
            // Completion is tested before expiry so a late finish still counts.
            ST_IM2COL: begin
                if (abort)            state_nxt = ST_IDLE;
                else if (im2col_done) state_nxt = ST_GEMM_GO;
                else if (wd_hit)      state_nxt = ST_ERR;
            end
            ST_GEMM_GO: begin
                if (abort) state_nxt = ST_IDLE;
                else       state_nxt = ST_GEMM;
            end
            ST_GEMM: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (gemm_done) state_nxt = ST_DONE;
                else if (wd_hit)    state_nxt = ST_ERR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Engine-facing controls are registered from the next state so they line
    // up exactly with the state they belong to, without combinational glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_NONE;
            rst_im2col <= 1'b1;
            gemm_start <= 1'b0;
        end else begin
            owner      <= owner_of(state_nxt);
            rst_im2col <= (state_nxt != ST_IM2COL);
            gemm_start <= (state_nxt == ST_GEMM_GO);
        end
    end

    // Watchdog restarts on every phase change and only counts in the two
    // phases that wait on an engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (state == ST_IM2COL || state == ST_GEMM) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (run_accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != {PERF_WIDTH{1'b1}})) begin
            perf_cycles <= perf_cycles + PERF_WIDTH'(1);
        end
    end

    conv_mem_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_mux (
        .owner       (owner),
        .i2c_addr_rd (i2c_addr_rd),
        .i2c_addr_wr (i2c_addr_wr),
        .i2c_data_wr (i2c_data_wr),
        .i2c_wr_en   (i2c_wr_en),
        .gm_addr_rd  (gm_addr_rd),
        .gm_addr_wr  (gm_addr_wr),
        .gm_data_wr  (gm_data_wr),
        .gm_wr_en    (gm_wr_en),
        .mem_addr_rd (mem_addr_rd),
        .mem_addr_wr (mem_addr_wr),
        .mem_data_wr (mem_data_wr),
        .mem_wr_en   (mem_wr_en)
    );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed runs of the convolution sequencer against a
// phase/age model of the control rules, with per-run literal expectations.
module tb_conv_seq_ctrl;

    localparam int TMO  = 600;   // watchdog limit, chosen to exceed a 576-write im2col phase
    localparam int N_WR = 576;   // 8x8 padded input, 3x3 kernel -> 64 columns x 9 taps

    localparam int PH_IDLE = 0, PH_I2C = 1, PH_GO = 2, PH_GEMM = 3, PH_DONE = 4, PH_ERR = 5;
    localparam int W_I2C = 0, W_GS = 1, W_ERR = 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0;
    logic        busy, done, err, rst_im2col, gemm_start;
    logic [31:0] perf_cycles;
    logic        im2col_done = 1'b0, gemm_done = 1'b0;
    logic [31:0] i2c_addr_rd = '0, i2c_addr_wr = '0, gm_addr_rd = '0, gm_addr_wr = '0;
    logic [7:0]  i2c_data_wr = '0, gm_data_wr = '0;
    logic        i2c_wr_en = 1'b0, gm_wr_en = 1'b0;
    logic [31:0] mem_addr_rd, mem_addr_wr;
    logic [7:0]  mem_data_wr;
    logic        mem_wr_en;
    logic [2:0]  state_dbg;

    conv_seq_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .perf_cycles(perf_cycles),
        .rst_im2col(rst_im2col), .im2col_done(im2col_done),
        .i2c_addr_rd(i2c_addr_rd), .i2c_addr_wr(i2c_addr_wr),
        .i2c_data_wr(i2c_data_wr), .i2c_wr_en(i2c_wr_en),
        .gemm_start(gemm_start), .gemm_done(gemm_done),
        .gm_addr_rd(gm_addr_rd), .gm_addr_wr(gm_addr_wr),
        .gm_data_wr(gm_data_wr), .gm_wr_en(gm_wr_en),
        .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr),
        .mem_data_wr(mem_data_wr), .mem_wr_en(mem_wr_en),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Phase plus age-in-phase; outputs follow from a per-phase table below.
    int          m_ph = PH_IDLE, m_age = 0;
    logic [31:0] m_perf = '0;

    function automatic logic ph_busy(input int p);
        return (p == PH_I2C) || (p == PH_GO) || (p == PH_GEMM);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int nxt;
        if (rst) begin
            m_ph <= PH_IDLE; m_age <= 0; m_perf <= '0;
        end else begin
            nxt = m_ph;
            if (m_ph == PH_IDLE || m_ph == PH_ERR) begin
                if (abort) nxt = PH_IDLE;
                else if (start) nxt = PH_I2C;
            end else if (m_ph == PH_DONE) nxt = PH_IDLE;
            else if (abort) nxt = PH_IDLE;
            else if (m_ph == PH_GO) nxt = PH_GEMM;
            else if ((m_ph == PH_I2C && im2col_done) || (m_ph == PH_GEMM && gemm_done)) nxt = m_ph + 1;
            else if (m_age + 1 >= TMO) nxt = PH_ERR;
            if ((m_ph == PH_IDLE || m_ph == PH_ERR) && start && !abort) m_perf <= '0;
            else if (ph_busy(m_ph) && m_perf != 32'hFFFF_FFFF) m_perf <= m_perf + 1;
            m_age <= (nxt == m_ph) ? m_age + 1 : 0;
            m_ph  <= nxt;
        end
    end

    // ---------------- compare process + event counters ----------------
    logic        cmp_en = 1'b0;
    int          n_gs, n_done, n_err, n_wr_i2c, n_wr_gm;
    logic [31:0] a_lo, a_hi;

    task automatic clr_cnt();
        n_gs = 0; n_done = 0; n_err = 0; n_wr_i2c = 0; n_wr_gm = 0;
        a_lo = 32'hFFFF_FFFF; a_hi = 32'h0;
    endtask

    always @(negedge clk) begin : compare
        logic [31:0] e_ar, e_aw;
        logic [7:0]  e_d;
        logic        e_we;
        if (cmp_en) begin
            {e_we, e_ar, e_aw, e_d} = '0;
            if (m_ph == PH_I2C) {e_we, e_ar, e_aw, e_d} = {i2c_wr_en, i2c_addr_rd, i2c_addr_wr, i2c_data_wr};
            else if (m_ph == PH_GO || m_ph == PH_GEMM) {e_we, e_ar, e_aw, e_d} = {gm_wr_en, gm_addr_rd, gm_addr_wr, gm_data_wr};
            chk("busy", busy, ph_busy(m_ph));
            chk("done", done, m_ph == PH_DONE);
            chk("err", err, m_ph == PH_ERR);
            chk("rst_im2col", rst_im2col, m_ph != PH_I2C);
            chk("gemm_start", gemm_start, m_ph == PH_GO);
            chk("perf_cycles", perf_cycles, m_perf);
            chk("mem_wr_en", mem_wr_en, e_we);
            chk("mem_addr_rd", mem_addr_rd, e_ar);
            chk("mem_addr_wr", mem_addr_wr, e_aw);
            chk("mem_data_wr", mem_data_wr, e_d);
            n_gs   += int'(gemm_start);
            n_done += int'(done);
            n_err  += int'(err);
            if (mem_wr_en && mem_addr_wr >= 32'h2000 && mem_addr_wr <= 32'h2FFF) begin
                n_wr_i2c++;
                if (mem_addr_wr < a_lo) a_lo = mem_addr_wr;
                if (mem_addr_wr > a_hi) a_hi = mem_addr_wr;
            end
            if (mem_wr_en && mem_addr_wr >= 32'h3000 && mem_addr_wr <= 32'h3FFF) n_wr_gm++;
        end
    end

    // ---------------- driver tasks ----------------
    int wn;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic seen(input int w);
        case (w)
            W_I2C:   return !rst_im2col;
            W_GS:    return gemm_start;
            default: return err;
        endcase
    endfunction

    task automatic wait_until(input int w, input int budget, input string nm, output int n);
        n = 0;
        while (!seen(w) && n < budget) begin
            step();
            n++;
        end
        chk(nm, seen(w), 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // im2col engine: one write per cycle once released, then a completion level.
    task automatic run_i2c(input int abort_at);
        wait_until(W_I2C, 8, "i2c_release", wn);
        for (int k = 0; k < N_WR; k++) begin
            i2c_wr_en   = 1'b1;
            i2c_addr_wr = 32'h2000 + k;
            i2c_addr_rd = 32'h1000 + k / 9;
            i2c_data_wr = 8'(k * 3);
            if (k == abort_at) abort = 1'b1;
            step();
            if (k == abort_at) begin
                abort = 1'b0;
                return;
            end
        end
        i2c_wr_en   = 1'b0;
        im2col_done = 1'b1;
        step();
        im2col_done = 1'b0;
    endtask

    // GEMM engine: four result writes, done pulse 10 cycles after gemm_start.
    task automatic run_gemm(input bit respond, input bit poke_start);
        wait_until(W_GS, 8, "gemm_launch", wn);
        for (int c = 1; c <= 10; c++) begin
            step();
            gm_wr_en   = (c <= 4);
            gm_addr_wr = 32'h3000 + c;
            gm_addr_rd = 32'h4000 + c;
            gm_data_wr = 8'(c + 8'h50);
            start      = poke_start && (c == 3 || c == 10);
            gemm_done  = respond && (c == 10);
        end
        step();
        gm_wr_en = 1'b0; start = 1'b0; gemm_done = 1'b0;
    endtask

    task automatic check_full_run(input string tag);
        chk({tag, "_i2c_writes"}, n_wr_i2c, N_WR);
        chk({tag, "_addr_lo"}, a_lo, 32'h2000);
        chk({tag, "_addr_hi"}, a_hi, 32'h223F);
        chk({tag, "_gm_writes"}, n_wr_gm, 4);
        chk({tag, "_gemm_starts"}, n_gs, 1);
        chk({tag, "_dones"}, n_done, 1);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_perf"}, perf_cycles, 588);
        chk({tag, "_model_perf"}, m_perf, 588);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_perf", perf_cycles, 0);
        chk("rst_im2col_hold", rst_im2col, 1'b1);
        chk("rst_gemm_start", gemm_start, 1'b0);
        chk("rst_mem_wr_en", mem_wr_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: full run
        clr_cnt();
        do_start();
        run_i2c(-1);
        run_gemm(1'b1, 1'b0);
        step(); step();
        check_full_run("t1");

        // 2: GEMM never answers -> watchdog, sticky err, restart clears it
        clr_cnt();
        do_start();
        run_i2c(-1);
        run_gemm(1'b0, 1'b0);
        wait_until(W_ERR, TMO + 50, "t2_err_raised", wn);
        chk("t2_err_latency", 11 + wn, TMO + 1);
        chk("t2_perf_hold", perf_cycles, 577 + 1 + TMO);
        gm_wr_en = 1'b1;
        repeat (5) step();
        chk("t2_err_sticky", err, 1'b1);
        chk("t2_mem_quiet", mem_wr_en, 1'b0);
        gm_wr_en = 1'b0;
        clr_cnt();
        do_start();
        chk("t2_err_cleared", err, 1'b0);
        chk("t2_restart_busy", busy, 1'b1);
        run_i2c(-1);
        run_gemm(1'b1, 1'b0);
        step(); step();
        check_full_run("t2");

        // 3: abort 100 cycles into im2col; writes still requested afterwards
        clr_cnt();
        do_start();
        run_i2c(99);
        chk("t3_idle", busy, 1'b0);
        chk("t3_hold", rst_im2col, 1'b1);
        chk("t3_mem_quiet", mem_wr_en, 1'b0);
        repeat (3) step();
        i2c_wr_en   = 1'b0;
        im2col_done = 1'b1;
        step();
        im2col_done = 1'b0;
        step();
        chk("t3_no_gemm_start", n_gs, 0);
        chk("t3_no_done", n_done, 0);
        chk("t3_perf", perf_cycles, 100);
        chk("t3_err", err, 1'b0);

        // 4: start pokes during GEMM and alongside gemm_done are ignored
        clr_cnt();
        do_start();
        run_i2c(-1);
        run_gemm(1'b1, 1'b1);
        step(); step();
        check_full_run("t4");
        chk("t4_idle_after", busy, 1'b0);

        // 5: im2col_done lands in the watchdog's final cycle
        clr_cnt();
        do_start();
        wait_until(W_I2C, 8, "t5_release", wn);
        repeat (TMO - 1) step();
        im2col_done = 1'b1;
        step();
        im2col_done = 1'b0;
        chk("t5_gemm_go", gemm_start, 1'b1);
        chk("t5_no_err", err, 1'b0);
        run_gemm(1'b1, 1'b0);
        step(); step();
        chk("t5_dones", n_done, 1);
        chk("t5_err_cycles", n_err, 0);
        chk("t5_perf", perf_cycles, TMO + 1 + 10);

        // 6: async reset mid-GEMM, then a clean run
        clr_cnt();
        do_start();
        run_i2c(-1);
        wait_until(W_GS, 8, "t6_launch", wn);
        step();
        gm_wr_en   = 1'b1;
        gm_addr_wr = 32'h5000;
        step();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_rst_im2col", rst_im2col, 1'b1);
        chk("t6_gemm_start", gemm_start, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_err", err, 1'b0);
        chk("t6_perf", perf_cycles, 0);
        chk("t6_mem_wr_en", mem_wr_en, 1'b0);
        step(); step();
        rst      = 1'b0;
        gm_wr_en = 1'b0;
        step();
        chk("t6_stays_idle", busy, 1'b0);
        clr_cnt();
        do_start();
        run_i2c(-1);
        run_gemm(1'b1, 1'b0);
        step(); step();
        check_full_run("t6");

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
